// File: rtl/core_pkg.sv
// Shared types for the writeback slice: register index, data word and
// result-source selector.
package core_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;

  typedef logic [4:0]      reg_idx_t;
  typedef logic [XLEN-1:0] word_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LU  = 1'b1
  } src_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for long-latency destinations; raises stall when a
// candidate instruction touches a register that still awaits its writeback.
module wb_scoreboard #(
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [4:0]      set_idx,
  input  logic            clr_en,
  input  logic [4:0]      clr_idx,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  input  logic [4:0]      chk_rd,
  output logic            stall,
  output logic [NREG-1:0] pending
);
  import core_pkg::*;

  // Bit 0 is only ever written by reset, so x0 can never look pending.
  // Set is evaluated before clear so a same-cycle collision keeps the bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (set_en && set_idx == reg_idx_t'(i)) begin
          pending[i] <= 1'b1;
        end else if (clr_en && clr_idx == reg_idx_t'(i)) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  assign stall = !rst && (pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd]);
endmodule

// File: rtl/writeback_scoreboard.sv
// Writeback arbiter for the register file's single write port, alternating
// between ALU and long-unit results under contention, plus hazard scoreboard.
module writeback_scoreboard #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lu_valid,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            lu_ready,
  input  logic            iss_valid,
  input  logic            iss_long,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  input  logic [4:0]      chk_rd,
  output logic            stall,
  output logic [4:0]      wb_sel,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_we,
  output logic [NREG-1:0] pending
);
  import core_pkg::*;

  logic            last_lu;
  logic            wb_from_lu;
  logic            accept;
  logic            set_en;
  src_t            grant;
  reg_idx_t        grant_rd;
  logic [XLEN-1:0] grant_data;

  // Long unit has priority unless it took the previous accepted slot.
  always_comb begin
    grant = SRC_ALU;
    if (lu_valid && (!alu_valid || !last_lu)) begin
      grant = SRC_LU;
    end
  end

  assign accept     = !rst && (alu_valid || lu_valid);
  assign alu_ready  = !rst && alu_valid && (grant == SRC_ALU);
  assign lu_ready   = !rst && lu_valid  && (grant == SRC_LU);
  assign grant_rd   = (grant == SRC_LU) ? lu_rd   : alu_rd;
  assign grant_data = (grant == SRC_LU) ? lu_data : alu_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we      <= 1'b0;
      wb_sel     <= '0;
      wb_data    <= '0;
      last_lu    <= 1'b0;
      wb_from_lu <= 1'b0;
    end else begin
      wb_from_lu <= 1'b0;
      if (accept) begin
        wb_sel     <= grant_rd;
        wb_data    <= grant_data;
        wb_we      <= (grant_rd != '0);
        last_lu    <= (grant == SRC_LU);
        wb_from_lu <= (grant == SRC_LU);
      end else begin
        wb_we <= 1'b0;
      end
    end
  end

  // wb_sel still holds the long-unit destination on the edge the file captures it.
  assign set_en = iss_valid && iss_long && (iss_rd != '0);

  wb_scoreboard #(
    .NREG(NREG)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (set_en),
    .set_idx (iss_rd),
    .clr_en  (wb_from_lu),
    .clr_idx (wb_sel),
    .chk_rs1 (chk_rs1),
    .chk_rs2 (chk_rs2),
    .chk_rd  (chk_rd),
    .stall   (stall),
    .pending (pending)
  );
endmodule

// File: tb/tb_writeback_scoreboard.sv
// Bench for writeback_scoreboard: queued sources, per-edge reference model,
// and a negedge monitor comparing the DUT against expected writes.
module tb_writeback_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lu_valid, alu_ready, lu_ready;
  logic [4:0]  alu_rd, lu_rd;
  logic [31:0] alu_data, lu_data;
  logic        iss_valid, iss_long;
  logic [4:0]  iss_rd, chk_rs1, chk_rs2, chk_rd;
  logic        stall;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;
  logic        wb_we;
  logic [31:0] pending;

  always #5 clk = ~clk;

  writeback_scoreboard #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .stall(stall),
    .wb_sel(wb_sel), .wb_data(wb_data), .wb_we(wb_we), .pending(pending)
  );

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } res_t;
  typedef struct packed { logic we; logic [4:0] sel; logic [31:0] data; logic [31:0] pend; } exp_t;

  res_t        alu_q[$];
  res_t        lu_q[$];
  exp_t        exp_q[$];
  logic [4:0]  wlog[$];
  logic [31:0] rf [32];

  logic        m_last_lu = 1'b0;
  logic [31:0] m_pend = '0;
  logic        m_clr_v = 1'b0;
  logic [4:0]  m_clr_idx = '0;
  logic        alu_acc = 1'b0, lu_acc = 1'b0;

  int checks = 0;
  int errors = 0;

  // {lu, alu}: long unit first unless it won the last accepted slot.
  function automatic logic [1:0] pick(input logic av, input logic lv, input logic last);
    if (lv && (!av || !last)) return 2'b10;
    if (av) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances at each rising edge from bench-driven inputs only.
  always @(posedge clk) begin
    exp_t        e;
    logic [1:0]  g;
    logic [31:0] np;
    e = '0;
    if (rst) begin
      m_last_lu = 1'b0;
      m_pend    = '0;
      m_clr_v   = 1'b0;
      alu_acc   = 1'b0;
      lu_acc    = 1'b0;
    end else begin
      g = pick(alu_valid, lu_valid, m_last_lu);
      alu_acc = g[0];
      lu_acc  = g[1];
      np = m_pend;
      if (m_clr_v) np[m_clr_idx] = 1'b0;
      if (iss_valid && iss_long && iss_rd != 5'd0) np[iss_rd] = 1'b1;
      m_clr_v = 1'b0;
      if (g[1]) begin
        e.we = (lu_rd != 5'd0); e.sel = lu_rd; e.data = lu_data;
        m_last_lu = 1'b1; m_clr_v = (lu_rd != 5'd0); m_clr_idx = lu_rd;
      end else if (g[0]) begin
        e.we = (alu_rd != 5'd0); e.sel = alu_rd; e.data = alu_data;
        m_last_lu = 1'b0;
      end
      m_pend = np;
      e.pend = np;
    end
    exp_q.push_back(e);
  end

  // Sources: present the queue head, retire it once the model says it was taken.
  always @(posedge clk) begin
    #1;
    if (alu_acc && alu_q.size() > 0) void'(alu_q.pop_front());
    if (lu_acc && lu_q.size() > 0) void'(lu_q.pop_front());
    if (alu_q.size() > 0) begin
      alu_valid = 1'b1; alu_rd = alu_q[0].rd; alu_data = alu_q[0].data;
    end else begin
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    end
    if (lu_q.size() > 0) begin
      lu_valid = 1'b1; lu_rd = lu_q[0].rd; lu_data = lu_q[0].data;
    end else begin
      lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    end
  end

  // Monitor: mid-cycle comparison of registered outputs and combinational handshakes.
  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] g;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL exp_queue: got empty expected entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("wb_we", {31'd0, wb_we}, {31'd0, e.we});
      if (e.we) begin
        check("wb_sel", {27'd0, wb_sel}, {27'd0, e.sel});
        check("wb_data", wb_data, e.data);
      end
      check("pending", pending, e.pend);
    end
    g = rst ? 2'b00 : pick(alu_valid, lu_valid, m_last_lu);
    check("alu_ready", {31'd0, alu_ready}, {31'd0, g[0]});
    check("lu_ready", {31'd0, lu_ready}, {31'd0, g[1]});
    check("stall", {31'd0, stall},
          {31'd0, !rst && (m_pend[chk_rs1] | m_pend[chk_rs2] | m_pend[chk_rd])});
    if (!rst && iss_valid && stall) begin
      checks++; errors++;
      $display("FAIL proto_issue_on_stall: got iss_valid=1 expected 0 at %0t", $time);
    end
    if (!rst && alu_valid && alu_ready && pending[alu_rd]) begin
      checks++; errors++;
      $display("FAIL proto_alu_to_pending: got rd=%0d expected non-pending at %0t", alu_rd, $time);
    end
    if (wb_we) begin
      wlog.push_back(wb_sel);
      rf[wb_sel] = wb_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    iss_valid = 1'b0; iss_long = 1'b0; iss_rd = '0;
  endtask

  task automatic drain();
    int n = 0;
    while ((alu_q.size() != 0 || lu_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (alu_q.size() != 0 || lu_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d queued expected 0/0", alu_q.size(), lu_q.size());
    end
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] order [8];
    logic [4:0] r, rs1, rs2;
    order = '{5'd9, 5'd1, 5'd10, 5'd2, 5'd11, 5'd3, 5'd12, 5'd4};
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    iss_valid = 1'b0; iss_long = 1'b0; iss_rd = '0;
    chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    for (int i = 1; i <= 4; i++) begin
      alu_q.push_back('{rd: 5'(i), data: 32'hA000_0000 + 32'(i)});
      lu_q.push_back('{rd: 5'(i + 8), data: 32'hB000_0000 + 32'(i)});
    end

    // Reset held while both sources are valid, then contention.
    tick(); tick(); tick();
    rst = 1'b0;
    drain();
    tick(); tick();
    check("order_count", 32'(wlog.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < wlog.size()) check("grant_order", {27'd0, wlog[i]}, {27'd0, order[i]});
    end
    wlog.delete();

    // ALU-only write.
    alu_q.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
    tick(); tick();
    @(negedge clk);
    check("alu_only_sel", {27'd0, wb_sel}, 32'd5);
    check("alu_only_data", wb_data, 32'hDEADBEEF);
    check("alu_only_we", {31'd0, wb_we}, 32'd1);
    tick();
    @(negedge clk);
    check("alu_only_we_drop", {31'd0, wb_we}, 32'd0);

    // Long write to x7 with a dependent candidate.
    chk_rs1 = 5'd7;
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd7;
    tick();
    @(negedge clk);
    check("sb_stall_c1", {31'd0, stall}, 32'd1);
    tick();
    lu_q.push_back('{rd: 5'd7, data: 32'h1234_5678});
    tick(); tick();
    @(negedge clk);
    check("sb_stall_c4", {31'd0, stall}, 32'd1);
    tick();
    @(negedge clk);
    check("sb_stall_c5", {31'd0, stall}, 32'd0);
    check("sb_rf_read", rf[7], 32'h1234_5678);
    chk_rs1 = '0;
    wlog.delete();

    // x0 destination: handshake completes, nothing written or tracked.
    lu_q.push_back('{rd: 5'd0, data: 32'h5555_5555});
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd0;
    drain();
    tick(); tick();
    check("x0_pending", pending, 32'd0);
    check("x0_no_write", 32'(wlog.size()), 32'd0);

    // Clear of x3 collides with a fresh long issue to x3.
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd3;
    tick();
    lu_q.push_back('{rd: 5'd3, data: 32'h3333_3333});
    tick(); tick();
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd3;
    tick();
    @(negedge clk);
    check("collide_pending3", {31'd0, pending[3]}, 32'd1);
    lu_q.push_back('{rd: 5'd3, data: 32'h3434_3434});
    drain();
    tick(); tick();
    check("collide_cleared", {31'd0, pending[3]}, 32'd0);

    // Reset mid-operation drops the scoreboard.
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd6;
    tick();
    @(negedge clk);
    check("midrst_set", {31'd0, pending[6]}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_clear", pending, 32'd0);
    tick();

    // Randomized traffic: ALU to x16..x31, long unit to x0..x15.
    for (int c = 0; c < 400; c++) begin
      if (alu_q.size() < 3 && $urandom_range(0, 2) == 0)
        alu_q.push_back('{rd: 5'(16 + $urandom_range(0, 15)), data: $urandom});
      r   = 5'($urandom_range(0, 15));
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      chk_rs1 = rs1; chk_rs2 = rs2; chk_rd = r;
      if ($urandom_range(0, 3) == 0 && !(m_pend[r] | m_pend[rs1] | m_pend[rs2])) begin
        iss_valid = 1'b1;
        iss_long  = 1'($urandom_range(0, 1));
        iss_rd    = r;
        if (iss_long) lu_q.push_back('{rd: r, data: $urandom});
      end
      tick();
    end
    chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    drain();
    tick(); tick(); tick();
    check("final_pending", pending, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
